// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-bus slice: access/status codes and arbiter state.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } rggen_arbiter_state;

    // Index width that stays legal for a single-entry vector.
    function automatic int rggen_index_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Pure combinational round-robin pick: first requester at or after the pointer, wrapping.
module rggen_round_robin_selector
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int POINTER_WIDTH = rggen_index_width(HOSTS)
)(
    input  logic [HOSTS-1:0]         i_request,
    input  logic [POINTER_WIDTH-1:0] i_pointer,
    output logic [HOSTS-1:0]         o_grant,
    output logic [POINTER_WIDTH-1:0] o_index,
    output logic                     o_found
);

    int pointer;
    int distance;
    int best;
    int selected;

    // Each requester's distance from the pointer is its priority; smallest wins.
    always_comb begin
        pointer  = int'(i_pointer);
        distance = 0;
        best     = HOSTS;
        selected = 0;
        o_found  = 1'b0;
        for (int h = 0; h < HOSTS; h++) begin
            distance = (h >= pointer) ? (h - pointer) : (h + HOSTS - pointer);
            if (i_request[h] && (distance < best)) begin
                best     = distance;
                selected = h;
                o_found  = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int h = 0; h < HOSTS; h++) begin
            o_grant[h] = o_found && (selected == h);
        end
        o_index = POINTER_WIDTH'(selected);
    end

endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one register-block bus port among HOSTS requesters.
// Optional watchdog enabled by defining RGGEN_ARBITER_TIMEOUT_EN.
module rggen_register_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [HOSTS-1:0]               i_host_valid,
    input  rggen_access                    i_host_access [HOSTS],
    input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
    input  logic [HOSTS*BUS_WIDTH-1:0]     i_host_write_data,
    input  logic [HOSTS*BUS_WIDTH/8-1:0]   i_host_strobe,
    output logic [HOSTS-1:0]               o_host_ready,
    output rggen_status                    o_host_status [HOSTS],
    output logic [BUS_WIDTH-1:0]           o_host_read_data,
    output logic [HOSTS-1:0]               o_grant,
    output logic                           o_valid,
    output rggen_access                    o_access,
    output logic [ADDRESS_WIDTH-1:0]       o_address,
    output logic [BUS_WIDTH-1:0]           o_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_strobe,
    input  logic                           i_ready,
    input  rggen_status                    i_status,
    input  logic [BUS_WIDTH-1:0]           i_read_data
);

    localparam int POINTER_WIDTH = rggen_index_width(HOSTS);
    localparam int STROBE_WIDTH  = BUS_WIDTH / 8;

    rggen_arbiter_state         state_q;
    logic [HOSTS-1:0]           grant_q;
    logic [POINTER_WIDTH-1:0]   index_q;
    logic [POINTER_WIDTH-1:0]   pointer_q;
    logic [POINTER_WIDTH-1:0]   pointer_next;
    logic [HOSTS-1:0]           select_grant;
    logic [POINTER_WIDTH-1:0]   select_index;
    logic                       select_found;
    logic                       in_access;
    logic                       timeout;
    logic                       complete;

    rggen_round_robin_selector #(
        .HOSTS          (HOSTS),
        .POINTER_WIDTH  (POINTER_WIDTH)
    ) u_selector (
        .i_request  (i_host_valid),
        .i_pointer  (pointer_q),
        .o_grant    (select_grant),
        .o_index    (select_index),
        .o_found    (select_found)
    );

    assign in_access    = (state_q == ACCESS);
    assign complete     = in_access && (i_ready || timeout);
    assign pointer_next = (index_q == POINTER_WIDTH'(HOSTS - 1)) ? '0 : index_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            index_q   <= '0;
            pointer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (select_found) begin
                        state_q <= ACCESS;
                        grant_q <= select_grant;
                        index_q <= select_index;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        pointer_q <= pointer_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RGGEN_ARBITER_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [COUNT_WIDTH-1:0] count_q;

    // Held at zero while idle so every access starts its budget afresh.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (!in_access) begin
            count_q <= '0;
        end else if (!i_ready && !timeout) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign timeout = in_access && !i_ready && (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign o_valid = in_access;
    assign o_grant = grant_q;

    always_comb begin
        o_access     = RGGEN_READ;
        o_address    = '0;
        o_write_data = '0;
        o_strobe     = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (grant_q[h]) begin
                o_access     = i_host_access[h];
                o_address    = i_host_address[h*ADDRESS_WIDTH+:ADDRESS_WIDTH];
                o_write_data = i_host_write_data[h*BUS_WIDTH+:BUS_WIDTH];
                o_strobe     = i_host_strobe[h*STROBE_WIDTH+:STROBE_WIDTH];
            end
        end
    end

    // A watchdog completion reports SLAVE_ERROR with zero data; a real ready always wins.
    always_comb begin
        for (int h = 0; h < HOSTS; h++) begin
            o_host_ready[h]  = complete && grant_q[h];
            o_host_status[h] = RGGEN_OKAY;
            if (complete && grant_q[h]) begin
                o_host_status[h] = i_ready ? i_status : RGGEN_SLAVE_ERROR;
            end
        end
        o_host_read_data = (complete && i_ready) ? i_read_data : '0;
    end

endmodule
